// File: rtl/mvu_csr_apb_initiator.sv
// APB requester for MVU CSR accesses: decodes the CSR window, runs one two-phase
// APB transfer at a time and returns read data plus a 2-bit status code.
module mvu_csr_apb_initiator #(
    parameter int unsigned NMVU           = 8,
    parameter int unsigned APB_ADDR_WIDTH = 15,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter logic [11:0] CSR_LO         = 12'hF20,
    parameter logic [11:0] CSR_HI         = 12'hF5C,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned BMVUA          = (NMVU > 1) ? $clog2(NMVU) : 1,
    localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [BMVUA-1:0]          req_mvu,
    input  logic [11:0]               req_csr,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_code,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [APB_STRB_WIDTH-1:0] pstrb,
    output logic [2:0]                pprot,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned TCW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_DECERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      req_ready_nxt, rsp_valid_nxt;
    logic                      psel_nxt, penable_nxt, pwrite_nxt;
    logic [APB_ADDR_WIDTH-1:0] paddr_nxt;
    logic [APB_DATA_WIDTH-1:0] pwdata_nxt, rsp_rdata_nxt;
    logic [APB_STRB_WIDTH-1:0] pstrb_nxt;
    logic [1:0]                rsp_code_nxt;
    logic [TCW-1:0]            tmo_cnt, tmo_cnt_nxt;
    logic                      csr_legal_c;

    assign pprot       = 3'b000;
    assign csr_legal_c = (req_csr >= CSR_LO) && (req_csr <= CSR_HI);

    // State and every output are registered; next values come from the block below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_code  <= '0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= req_ready_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            pstrb     <= pstrb_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_code  <= rsp_code_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready_nxt = req_ready;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        pstrb_nxt     = pstrb;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_code_nxt  = rsp_code;
        tmo_cnt_nxt   = tmo_cnt;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    req_ready_nxt = 1'b0;
                    if (csr_legal_c) begin
                        state_nxt  = SETUP;
                        psel_nxt   = 1'b1;
                        paddr_nxt  = APB_ADDR_WIDTH'({req_mvu, req_csr});
                        pwrite_nxt = req_write;
                        pwdata_nxt = req_wdata;
                        pstrb_nxt  = {APB_STRB_WIDTH{req_write}};
                    end else begin
                        // Out-of-window CSR: answer immediately, never touch the bus.
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_code_nxt  = RSP_DECERR;
                        rsp_rdata_nxt = '0;
                    end
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
                tmo_cnt_nxt = '0;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (pready) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_code_nxt  = pslverr ? RSP_SLVERR : RSP_OK;
                    rsp_rdata_nxt = (!pwrite && !pslverr) ? prdata : '0;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TCW'(TO_LAST))) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_code_nxt  = RSP_TIMEOUT;
                    rsp_rdata_nxt = '0;
                end else begin
                    tmo_cnt_nxt = TCW'(tmo_cnt + 1'b1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mvu_csr_apb_initiator.sv
// Directed bench for mvu_csr_apb_initiator: a scoreboard queue holds expected responses,
// a monitor pops them on each response handshake; a small APB slave model answers transfers.
`timescale 1ns/1ps
module tb_mvu_csr_apb_initiator;

    localparam logic [1:0] C_OK = 2'b00, C_SLV = 2'b01, C_DEC = 2'b10, C_TMO = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_mvu;
    logic [11:0] req_csr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic [14:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  code;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Slave model configuration
    int          sl_waits = 0;
    logic        sl_stuck = 1'b0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = '0;

    always #5 clk = ~clk;

    mvu_csr_apb_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_mvu(req_mvu), .req_csr(req_csr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // APB slave: asserts pready on ACCESS cycle number sl_waits (0-based) unless stuck
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (!sl_stuck && acc_cnt == sl_waits) begin
                    pready  = 1'b1;
                    pslverr = sl_err;
                    prdata  = sl_rdata;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b0;
                    prdata  = '0;
                end
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '0;
                acc_cnt = 0;
            end
        end
    end

    // Response monitor: compare each handshaked response against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual code=%0h required=no response", rsp_code);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_code", 64'(rsp_code), 64'(e.code));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    task automatic xfer(input string tag, input logic wr, input logic [2:0] mvu,
                        input logic [11:0] csr, input logic [31:0] wd, input int waits,
                        input logic stuck, input logic err, input logic [31:0] rd,
                        input logic [1:0] ecode, input logic [31:0] erdata,
                        input int elat, input int hold);
        exp_t e;
        int   lat, npsel, nen, exp_en;
        logic legal;
        legal  = (ecode != C_DEC);
        exp_en = !legal ? 0 : (stuck ? 4 : waits + 1);
        sl_waits = waits; sl_stuck = stuck; sl_err = err; sl_rdata = rd;
        @(negedge clk);
        chk({tag, "_req_ready_idle"}, 64'(req_ready), 64'(1));
        e.rdata = erdata;
        e.code  = ecode;
        exp_q.push_back(e);
        req_valid = 1'b1; req_write = wr; req_mvu = mvu; req_csr = csr; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        // Scramble request fields: the DUT must ignore them outside IDLE
        req_valid = 1'b0; req_write = ~wr; req_mvu = ~mvu; req_csr = 12'h000; req_wdata = ~wd;
        lat = 1; npsel = 0; nen = 0;
        while (!rsp_valid && lat <= 40) begin
            if (lat == 1) begin
                chk({tag, "_setup_penable"}, 64'(penable), 64'(0));
                chk({tag, "_busy_req_ready"}, 64'(req_ready), 64'(0));
            end
            if (psel) begin
                npsel++;
                chk({tag, "_paddr"}, 64'(paddr), 64'({mvu, csr}));
                chk({tag, "_pwrite"}, 64'(pwrite), 64'(wr));
                chk({tag, "_pstrb"}, 64'(pstrb), wr ? 64'hF : 64'h0);
                if (wr) chk({tag, "_pwdata"}, 64'(pwdata), 64'(wd));
            end
            if (penable) nen++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_resp_psel"}, 64'({psel, penable}), 64'(0));
        chk({tag, "_psel_cycles"}, 64'(npsel), legal ? 64'(exp_en + 1) : 64'(0));
        chk({tag, "_penable_cycles"}, 64'(nen), 64'(exp_en));
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, "_hold_code"}, 64'(rsp_code), 64'(ecode));
            chk({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(erdata));
            chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'(0));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_post_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_post_req_ready"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_mvu = '0; req_csr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_psel", 64'({psel, penable, pwrite}), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_paddr", 64'(paddr), 64'(0));
        chk("reset_pwdata_pstrb", 64'({pwdata, pstrb}), 64'(0));
        chk("reset_rsp", 64'({rsp_rdata, rsp_code}), 64'(0));
        chk("reset_pprot", 64'(pprot), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        //   tag        wr    mvu   csr      wdata          waits stuck err   prdata         code   rdata          lat hold
        xfer("wr_zw",   1'b1, 3'd3, 12'hF46, 32'h0000_0802, 0,    1'b0, 1'b0, 32'hFFFF_FFFF, C_OK,  32'h0,         3,  0);
        xfer("rd_2w",   1'b0, 3'd7, 12'hF47, 32'h1111_2222, 2,    1'b0, 1'b0, 32'hDEAD_BEEF, C_OK,  32'hDEAD_BEEF, 5,  0);
        xfer("rd_lo",   1'b0, 3'd1, 12'hF10, 32'h0,         0,    1'b0, 1'b0, 32'h1234_5678, C_DEC, 32'h0,         1,  0);
        xfer("rd_hi",   1'b0, 3'd6, 12'hF5D, 32'h0,         0,    1'b0, 1'b0, 32'h1234_5678, C_DEC, 32'h0,         1,  0);
        xfer("wr_err",  1'b1, 3'd2, 12'hF20, 32'hABCD_0123, 0,    1'b0, 1'b1, 32'h0,         C_SLV, 32'h0,         3,  4);
        xfer("rd_err",  1'b0, 3'd4, 12'hF20, 32'h0,         1,    1'b0, 1'b1, 32'h5555_AAAA, C_SLV, 32'h0,         4,  0);
        xfer("rd_tmo",  1'b0, 3'd5, 12'hF30, 32'h0,         0,    1'b1, 1'b0, 32'h1234_5678, C_TMO, 32'h0,         6,  0);
        xfer("rd_edge", 1'b0, 3'd0, 12'hF5C, 32'h0,         3,    1'b0, 1'b0, 32'hCAFE_F00D, C_OK,  32'hCAFE_F00D, 6,  0);

        // Reset while a transfer sits in ACCESS
        sl_stuck = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_mvu = 3'd5; req_csr = 12'hF30;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!penable && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reached_access", 64'(penable), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_psel", 64'({psel, penable}), 64'(0));
        chk("rst_async_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sl_stuck = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_req_ready", 64'(req_ready), 64'(1));
        chk("rst_release_rsp_valid", 64'(rsp_valid), 64'(0));
        xfer("wr_post", 1'b1, 3'd0, 12'hF5C, 32'hA5A5_A5A5, 0, 1'b0, 1'b0, 32'h0, C_OK, 32'h0, 3, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mvu_csr_apb_initiator.md
Name: mvu_csr_apb_initiator

Overview:
APB requester that turns single CSR access requests (MVU index, CSR number, data) into APB transfers toward the MVU CSR slaves. It sits between the host/controller command path and the shared MVU APB bus. It decodes the CSR map range, runs the standard two-phase APB transfer, and returns read data and a status code per request. One transfer is outstanding at a time.

Parameters:
NMVU, 8, number of MVUs; BMVUA = $clog2(NMVU)
APB_ADDR_WIDTH, 15, paddr width = BMVUA + 12
APB_DATA_WIDTH, 32, pwdata/prdata width; APB_STRB_WIDTH = APB_DATA_WIDTH/8
CSR_LO, 12'hF20, lowest legal CSR (CSR_MVUWBASEPTR)
CSR_HI, 12'hF5C, highest legal CSR (CSR_MVUUSEHPADDER)
TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait cycles; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_mvu  in  BMVUA  target MVU
req_csr  in  12  CSR number
req_wdata  in  APB_DATA_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  APB_DATA_WIDTH  read data
rsp_code  out  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
paddr  out  APB_ADDR_WIDTH  {req_mvu, req_csr}
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  APB_DATA_WIDTH  APB write data
pstrb  out  APB_STRB_WIDTH  all ones on write, zero on read
pprot  out  3  constant 3'b000
prdata  in  APB_DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On reset: state=IDLE; psel, penable, pwrite, rsp_valid = 0; paddr, pwdata, pstrb, rsp_rdata, rsp_code = 0; timeout counter = 0.
- State machine: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. Also IDLE -> RESP directly on a decode error.
- All APB and response outputs are registered.
- IDLE: req_ready=1; req_ready=0 in every other state.
  - On accept, if CSR_LO <= req_csr <= CSR_HI: latch paddr, pwrite, pwdata and pstrb, then go to SETUP.
  - Otherwise go to RESP with rsp_code=10 and rsp_rdata=0. No APB activity occurs.
- SETUP (exactly 1 cycle): psel=1, penable=0.
- ACCESS: psel=1, penable=1. paddr, pwrite, pwdata and pstrb are held stable. Stay in ACCESS until pready=1.
  - On pready: rsp_code = pslverr ? 01 : 00.
  - rsp_rdata = prdata only for an OK read; otherwise rsp_rdata = 0.
  - Next cycle: psel=0, penable=0, state=RESP.
- Timeout: the counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. If the count reaches TIMEOUT_CYCLES (nonzero) with pready still 0, drop psel and penable, then go to RESP with rsp_code=11 and rsp_rdata=0. If pready=1 arrives in the same cycle as the limit, the transfer completes normally.
- RESP: rsp_valid=1, and the response is held stable until rsp_ready. On rsp_valid & rsp_ready, rsp_valid drops and the state returns to IDLE. The next request is accepted no earlier than the following cycle, so there is no back-to-back accept in the handshake cycle.
- Latency, legal CSR, zero-wait slave: accept at cycle T; SETUP at T+1; ACCESS at T+2; rsp_valid at T+3. Each slave wait state adds 1 cycle.
- Latency, decode error: rsp_valid at T+1, and psel never asserts.
- Request fields are ignored outside IDLE. pready and pslverr are ignored when psel=0.
- Reset mid-transfer: psel and penable drop immediately (asynchronously), and any pending response is discarded.

Test Plan:
- Write mvu=3, csr=F46, data=0x0000_0802, zero-wait slave -> paddr=0x3F46, pwrite=1, pstrb=4'hF; SETUP at T+1, ACCESS at T+2; rsp_valid at T+3 with code 00.
- Read mvu=7, csr=F47, slave inserts 2 wait states, prdata=0xDEAD_BEEF -> penable held 3 cycles; rsp_rdata=0xDEADBEEF, code 00, rsp_valid at T+5.
- Read csr=F10 (below CSR_LO), then csr=F5D (above CSR_HI) -> psel stays 0; each returns rsp_valid at T+1 with code 10 and rdata=0.
- Write with pslverr=1 alongside pready; hold rsp_ready low for 4 cycles -> code 01; rsp_valid, rsp_code and rsp_rdata stable until rsp_ready; req_ready=0 throughout.
- TIMEOUT_CYCLES=4, pready stuck at 0 -> 4 ACCESS cycles, then psel=0 and code 11. Repeat with pready=1 on the 4th cycle -> code 00.
- Assert rst_n=0 during ACCESS -> psel, penable and rsp_valid drop immediately. After release, req_ready=1 and a new write completes normally.
